mdu32: RTL and testbench
========================

Name: mdu32

Overview:
- Iterative 32-bit multiply/divide unit in the MIPS execute stage, alongside the 32-bit ALU.
- Consumes the same A/B operands the ALU receives.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers.
- HI/LO are read by the writeback mux for MFHI/MFLO. The pipeline stalls while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported; the parameter exists for readability of the width arithmetic.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  launch the operation selected by op; sampled only when busy=0
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- A  input  32  multiplicand / dividend; also MTHI/MTLO write data
- B  input  32  multiplier / divisor
- mthi  input  1  write A into HI (idle only)
- mtlo  input  1  write A into LO (idle only)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO have been updated (or div-by-zero was flagged)
- divzero  output  1  last DIV/DIVU had B=0; held until the next accepted start
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (synchronous, active-high, clk and reset ports as above):
  - On any edge with reset=1: state=IDLE; hi=0, lo=0, busy=0, done=0, divzero=0; internal counter and work registers cleared.
  - Reset mid-operation aborts the operation with no HI/LO write.
- States:
  - IDLE: waiting for start, mthi or mtlo.
  - CALC: one iteration per cycle.
  - FIN: sign fixup and HI/LO write.
- Launch at edge E0, in IDLE with start=1:
  - Latch op and sign flags sA=A[31], sB=B[31] (signed ops only).
  - Work registers take |A| and |B| for signed ops, raw values for unsigned ops.
  - Clear the 5-bit counter, clear divzero, go to CALC, busy=1.
- Divide by zero: op=DIV/DIVU with B=0 at E0.
  - Go to FIN instead of CALC.
  - At E0+1: divzero=1, done=1, HI/LO unchanged, state goes to IDLE.
- Multiply, CALC: shift-add, one multiplier bit per edge, 64-bit product accumulator.
- Divide, CALC: restoring divide, one quotient bit per edge, 32-bit remainder and quotient.
- CALC iterations run on edges E0+1 .. E0+32. The edge of the 32nd iteration moves the state to FIN.
- FIN, at edge E0+33:
  - Apply the sign fix and write HI/LO, then go to IDLE.
  - busy drops and done=1 for exactly the following cycle.
- Results:
  - Multiply: {hi,lo} = 64-bit product; negated if sA^sB for MULT.
  - Divide: lo = quotient, negated if sA^sB; hi = remainder, negated if sA (DIV).
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- busy: 1 from the cycle after E0 through the cycle before done; 0 in the cycle done is high.
- start while busy=1: ignored, with no queueing.
- mthi / mtlo:
  - Idle only; hi<=A or lo<=A on the next edge. Both may assert together.
  - Ignored while busy=1.
  - If start=1 on the same edge, start wins and mthi/mtlo are dropped.
  - They do not pulse done.
- A and B may change freely after E0.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: multiply ops leave CALC early.
  - On an iteration edge, if the remaining unconsumed multiplier bits are all zero, or the counter has reached 31, go to FIN.
  - FIN write/done therefore occurs at E0+k+2, where k is the index of the highest set bit of the magnitude of B; k=0 when B is 0 or 1.
  - Divide and div-by-zero timing are unchanged.
- Undefined: every multiply takes the fixed 33-cycle latency. The early-out logic is absent.

Test Plan:
- Reset with hi/lo loaded; assert reset for 1 cycle -> hi=0, lo=0, busy=0, done=0, divzero=0 on the next cycle.
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> done at E0+33: hi=0xFFFFFFFE, lo=0x00000001. Without the macro, MULTU A=5 B=0 -> done at E0+33, hi=0, lo=0. With MDU_EARLY_OUT_EN: MULT A=7 B=1 -> done at E0+2, hi=0, lo=7; MULT A=-3 (0xFFFFFFFD) B=4 -> done at E0+4, {hi,lo}=0xFFFFFFFF_FFFFFFF4.
- DIV A=-7 (0xFFFFFFF9) B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=100 B=7 -> lo=14, hi=2. Both done at E0+33.
- DIVU A=9 B=0 with prior hi=0x11, lo=0x22 -> done at E0+1, divzero=1, hi/lo unchanged. The next accepted start clears divzero.
- Busy protection: MULTU 3*4 started; at E0+10 assert start (DIVU), mthi A=0xDEAD -> both ignored, lo=12, hi=0. Idle mthi and mtlo with A=0xABCD on the same edge -> hi=lo=0xABCD, no done. Reset at E0+15 -> IDLE, hi/lo=0, no done pulse.

Source files
------------

// File: rtl/mdu32.sv
// rtl/mdu32.sv - Iterative 32-bit MIPS multiply/divide unit holding HI/LO.
// Optional: define MDU_EARLY_OUT_EN to let multiplies leave CALC once the multiplier is exhausted.
module mdu32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state;
    logic                 op_is_div;
    logic                 sign_a;
    logic                 sign_b;
    logic                 dz_pend;
    logic [4:0]           cnt;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     dvsr;

    // Signed ops work on magnitudes; 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    logic                 neg_a;
    logic                 neg_b;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic                 b_zero;

    assign neg_a  = op[0] & A[WIDTH-1];
    assign neg_b  = op[0] & B[WIDTH-1];
    assign abs_a  = neg_a ? -A : A;
    assign abs_b  = neg_b ? -B : B;
    assign b_zero = (B == '0);

    // Restoring divide step: shift the next dividend bit into the partial remainder.
    logic [WIDTH:0]       rem_ext;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_sub;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     quot_next;

    assign rem_ext   = {rem, quot[WIDTH-1]};
    assign rem_ge    = (rem_ext >= {1'b0, dvsr});
    assign rem_sub   = rem_ext[WIDTH-1:0] - dvsr;
    assign rem_next  = rem_ge ? rem_sub : rem_ext[WIDTH-1:0];
    assign quot_next = {quot[WIDTH-2:0], rem_ge};

    logic [2*WIDTH-1:0]   prod_next;
    assign prod_next = mplier[0] ? (prod + mcand) : prod;

    logic                 mul_last;
`ifdef MDU_EARLY_OUT_EN
    assign mul_last = (cnt == 5'd31) || (mplier[WIDTH-1:1] == '0);
`else
    assign mul_last = (cnt == 5'd31);
`endif

    logic                 calc_last;
    assign calc_last = op_is_div ? (cnt == 5'd31) : mul_last;

    logic                 neg_prod;
    logic                 neg_quot;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign neg_prod = sign_a ^ sign_b;
    assign neg_quot = sign_a ^ sign_b;
    assign prod_fix = neg_prod ? -prod : prod;
    assign quot_fix = neg_quot ? -quot : quot;
    assign rem_fix  = sign_a ? -rem : rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_is_div <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            dz_pend   <= 1'b0;
            cnt       <= '0;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            quot      <= '0;
            dvsr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            divzero   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_is_div <= op[1];
                        sign_a    <= neg_a;
                        sign_b    <= neg_b;
                        dz_pend   <= op[1] & b_zero;
                        cnt       <= '0;
                        prod      <= '0;
                        mcand     <= {{WIDTH{1'b0}}, abs_a};
                        mplier    <= abs_b;
                        rem       <= '0;
                        quot      <= abs_a;
                        dvsr      <= abs_b;
                        divzero   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (op[1] && b_zero) ? FIN : CALC;
                    end else begin
                        if (mthi) hi <= A;
                        if (mtlo) lo <= A;
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (op_is_div) begin
                        rem  <= rem_next;
                        quot <= quot_next;
                    end else begin
                        prod   <= prod_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    if (calc_last) state <= FIN;
                end
                FIN: begin
                    if (dz_pend) begin
                        divzero <= 1'b1;
                    end else if (op_is_div) begin
                        lo <= quot_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu32.sv
// tb/tb_mdu32.sv - Scoreboard bench for mdu32 with a behavioural reference model.
module tb_mdu32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic        divzero;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu32 #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .divzero(divzero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        longint      t0;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa;
        longint      sb_;
        logic [31:0] mag;
        int          k;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        e.hi = m_hi;
        e.lo = m_lo;
        e.dz = 1'b0;
        e.t0 = 0;
        e.lat = 33;
        e.name = "";
        case (o)
            2'd0: begin
                p = {32'h0, a} * {32'h0, b};
                {e.hi, e.lo} = p;
            end
            2'd1: begin
                p = 64'(sa * sb_);
                {e.hi, e.lo} = p;
            end
            2'd2: begin
                if (b == 0) begin
                    e.dz = 1'b1; e.lat = 1;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            default: begin
                if (b == 0) begin
                    e.dz = 1'b1; e.lat = 1;
                end else begin
                    p = 64'(sa / sb_);
                    e.lo = p[31:0];
                    p = 64'(sa % sb_);
                    e.hi = p[31:0];
                end
            end
        endcase
`ifdef MDU_EARLY_OUT_EN
        if (o[1] == 1'b0) begin
            mag = (o[0] && b[31]) ? (32'h0 - b) : b;
            k = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) k = i;
            e.lat = k + 2;
        end
`else
        mag = b;
        k = 0;
        if (mag[0] && k < 0) e.lat = 0;
`endif
        return e;
    endfunction

    exp_t   mon_e;
    longint mon_lat;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 expected no done at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                mon_lat = ($time - mon_e.t0 - 5) / 10;
                check({mon_e.name, "_hi"}, hi, mon_e.hi);
                check({mon_e.name, "_lo"}, lo, mon_e.lo);
                check({mon_e.name, "_divzero"}, {31'h0, divzero}, {31'h0, mon_e.dz});
                check({mon_e.name, "_latency"}, 32'(mon_lat), 32'(mon_e.lat));
                check({mon_e.name, "_busy_at_done"}, {31'h0, busy}, 32'h0);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
        exp_t e;
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        e = model(o, a, b);
        e.name = name;
        @(posedge clk);
        e.t0 = longint'($time);
        sb.push_back(e);
        if (!e.dz) begin
            m_hi = e.hi;
            m_lo = e.lo;
        end
        @(negedge clk);
        start = 1'b0;
        A = $urandom; B = $urandom; op = 2'($urandom);
        check({name, "_divzero_clr"}, {31'h0, divzero}, 32'h0);
        check({name, "_busy"}, {31'h0, busy}, 32'h1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic mt(input logic do_hi, input logic do_lo, input logic [31:0] a);
        @(negedge clk);
        mthi = do_hi; mtlo = do_lo; A = a;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        if (do_hi) m_hi = a;
        if (do_lo) m_lo = a;
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'd0; A = 32'h0; B = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_divzero", {31'h0, divzero}, 32'h0);

        mt(1'b1, 1'b1, 32'h1234_5678);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0;
        check("rst2_hi", hi, 32'h0);
        check("rst2_lo", lo, 32'h0);
        check("rst2_busy", {31'h0, busy}, 32'h0);

        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max"); wait_idle();
        issue(2'd0, 32'd5, 32'd0, "multu_b0");                  wait_idle();
        issue(2'd1, 32'd7, 32'd1, "mult_7x1");                  wait_idle();
        issue(2'd1, 32'hFFFF_FFFD, 32'd4, "mult_m3x4");         wait_idle();
        issue(2'd3, 32'hFFFF_FFF9, 32'd2, "div_m7_2");          wait_idle();
        issue(2'd2, 32'd100, 32'd7, "divu_100_7");              wait_idle();
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");   wait_idle();

        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        issue(2'd2, 32'd9, 32'd0, "divu_dz"); wait_idle();
        check("dz_held", {31'h0, divzero}, 32'h1);
        issue(2'd2, 32'd9, 32'd3, "divu_after_dz"); wait_idle();

        issue(2'd0, 32'd3, 32'd4, "multu_busy");
        repeat (9) @(negedge clk);
        start = 1'b1; op = 2'd2; mthi = 1'b1; A = 32'hDEAD; B = 32'd5;
        check("busy_prot_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        wait_idle();
        check("busy_prot_hi", hi, 32'h0);
        check("busy_prot_lo", lo, 32'd12);

        mt(1'b1, 1'b1, 32'hABCD);

        issue(2'd2, 32'h1234_5678, 32'd77, "divu_abort");
        repeat (14) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        repeat (40) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'h0;
                1:       rb = $urandom >> $urandom_range(0, 31);
                2:       rb = $urandom_range(0, 3);
                3:       rb = 32'h0 - $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) mt(1'($urandom), 1'($urandom), $urandom);
            issue(ro, ra, rb, "rand");
            wait_idle();
        end

        check("final_hi", hi, m_hi);
        check("final_lo", lo, m_lo);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
